// File: rtl/mem_port_arbiter.sv
// Shares one pipelined single-port memory between instruction fetch and load/store.
// Data has priority, fetch gets a bounded-starvation guarantee, read data returns one cycle after the grant.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_rdun,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_size,
  output logic              m_rdun,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RESP_F = 2'd1;
  localparam logic [1:0] RESP_D = 2'd2;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] starve_cnt;
  logic       data_first;

  assign data_first = d_req && (starve_cnt < LIMIT);

  // Grants are masked while reset is asserted so every output settles to its reset value without a clock.
  always_comb begin
    // NOTE: every always_comb assigns defaults first, so no path can infer a latch.
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      if (data_first)  d_gnt = 1'b1;
      else if (f_req)  f_gnt = 1'b1;
      else if (d_req)  d_gnt = 1'b1;
    end
  end

  assign f_stall = f_req & ~f_gnt;
  assign m_en    = f_gnt | d_gnt;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_size  = 2'b00;
    m_rdun  = 1'b0;
    if (f_gnt) begin
      m_addr = f_addr;
      m_size = SIZE_WORD;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_size  = d_size;
      m_rdun  = d_rdun;
    end
  end

  // State names the owner of the read data arriving next cycle; stores complete at grant.
  always_comb begin
    state_nxt = IDLE;
    if (f_gnt)             state_nxt = RESP_F;
    else if (d_gnt && !d_we) state_nxt = RESP_D;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: registered state uses non-blocking assignments only.
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (f_req && !f_gnt) begin
        if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  always_comb begin
    f_rvalid = 1'b0;
    f_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (state == RESP_F) begin
      f_rvalid = 1'b1;
      f_rdata  = m_rdata;
    end else if (state == RESP_D) begin
      d_rvalid = 1'b1;
      d_rdata  = m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference model predicts grants and memory drive,
// queues expected read responses, and an independent monitor checks the routed data.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_req, f_gnt, f_rvalid, f_stall;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_we, d_rdun, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic        m_en, m_we, m_rdun;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .f_stall(f_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdun(d_rdun), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_rdun(m_rdun), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Memory environment: 16 words, read data appears the cycle after a read strobe.
  logic [31:0] env_mem [16];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
      mem_init <= 1'b1;
      m_rdata  <= $urandom;
    end else begin
      if (m_en && m_we) env_mem[m_addr[5:2]] <= m_wdata;
      m_rdata <= (m_en && !m_we) ? env_mem[m_addr[5:2]] : $urandom;
    end
  end

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ref_mem [16];
  int          denied;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expected response per read strobe of the previous cycle.
  always @(negedge clk) begin
    resp_t e;
    logic  ef, ed;
    ef = 1'b0; ed = 1'b0; e = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ef = !e.is_d;
      ed = e.is_d;
    end
    check("f_rvalid", 64'(f_rvalid), 64'(ef));
    check("d_rvalid", 64'(d_rvalid), 64'(ed));
    check("f_rdata",  64'(f_rdata),  64'(ef ? e.data : 32'h0));
    check("d_rdata",  64'(d_rdata),  64'(ed ? e.data : 32'h0));
  end

  task automatic drive_cycle(input logic fr, input logic [31:0] fa,
                             input logic dr, input logic dwe, input logic [31:0] da,
                             input logic [31:0] dwd, input logic [1:0] ds, input logic drun,
                             output logic got_f, output logic got_d);
    logic ef, ed;
    @(negedge clk);
    f_req = fr; f_addr = fa;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_size = ds; d_rdun = drun;
    #1;
    ed = dr && ((denied < STARVE_LIMIT) || !fr);
    ef = fr && !ed;
    check("f_gnt",   64'(f_gnt),   64'(ef));
    check("d_gnt",   64'(d_gnt),   64'(ed));
    check("f_stall", 64'(f_stall), 64'(fr && !ef));
    check("m_en",    64'(m_en),    64'(ef || ed));
    check("m_we",    64'(m_we),    64'(ed && dwe));
    check("m_addr",  64'(m_addr),  64'(ef ? fa : ed ? da : 32'h0));
    check("m_wdata", 64'(m_wdata), 64'(ed ? dwd : 32'h0));
    check("m_size",  64'(m_size),  64'(ef ? 2'b10 : ed ? ds : 2'b00));
    check("m_rdun",  64'(m_rdun),  64'(ed && drun));
    if (ef) sb.push_back('{is_d: 1'b0, data: ref_mem[fa[5:2]]});
    if (ed && !dwe) sb.push_back('{is_d: 1'b1, data: ref_mem[da[5:2]]});
    if (ed && dwe) ref_mem[da[5:2]] = dwd;
    if (fr && !ef) denied = (denied < STARVE_LIMIT) ? denied + 1 : denied;
    else denied = 0;
    got_f = ef;
    got_d = ed;
  endtask

  initial begin
    logic        gf, gd;
    logic [9:0]  pat;
    logic        pf, pd, pwe, prun;
    logic [31:0] pfa, pda, pwd;
    logic [1:0]  psz;

    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    denied = 0;
    reset_n = 1'b0;
    f_req = 1'b1; f_addr = BASE; d_req = 1'b1; d_we = 1'b0; d_addr = BASE;
    d_wdata = 32'h0; d_size = 2'b00; d_rdun = 1'b0;
    #3;
    check("rst_f_gnt",  64'(f_gnt),  64'd0);
    check("rst_d_gnt",  64'(d_gnt),  64'd0);
    check("rst_m_en",   64'(m_en),   64'd0);
    check("rst_f_stall", 64'(f_stall), 64'd1);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    f_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Fetch only
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, BASE, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, gf, gd);
    // Load collides with fetch, then fetch is granted
    drive_cycle(1'b1, BASE + 32'h4, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 2'b00, 1'b1, gf, gd);
    drive_cycle(1'b1, BASE + 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, gf, gd);
    // Store then read back
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 2'b10, 1'b0, gf, gd);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 2'b10, 1'b0, gf, gd);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, gf, gd);

    // Starvation: fetch wins once after STARVE_LIMIT data grants
    pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, BASE + 32'h20, 1'b1, 1'b0, BASE + 32'h30, 32'h0, 2'b10, 1'b0, gf, gd);
      check("starve_pattern", 64'(gf), 64'(pat[i]));
    end

    // Reset while a fetch read is being granted
    @(negedge clk);
    f_req = 1'b1; f_addr = BASE + 32'h3C; d_req = 1'b0;
    #1 check("pre_rst_f_gnt", 64'(f_gnt), 64'd1);
    #1 reset_n = 1'b0;
    sb.delete();
    denied = 0;
    #1;
    check("mid_rst_f_gnt",   64'(f_gnt),   64'd0);
    check("mid_rst_m_en",    64'(m_en),    64'd0);
    check("mid_rst_f_stall", 64'(f_stall), 64'd1);
    check("mid_rst_m_addr",  64'(m_addr),  64'd0);
    check("mid_rst_f_rvalid", 64'(f_rvalid), 64'd0);
    @(negedge clk);
    f_req = 1'b0;
    #2 reset_n = 1'b1;
    drive_cycle(1'b1, BASE + 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, gf, gd);

    // Random traffic; requesters hold their fields until granted
    pf = 1'b0; pd = 1'b0; pwe = 1'b0; prun = 1'b0;
    pfa = BASE; pda = BASE; pwd = 32'h0; psz = 2'b00;
    for (int n = 0; n < 400; n++) begin
      if (!pf) begin
        pf  = ($urandom_range(0, 9) < 7);
        pfa = BASE | (32'($urandom_range(0, 15)) << 2);
      end
      if (!pd) begin
        pd   = ($urandom_range(0, 9) < 6);
        pwe  = ($urandom_range(0, 9) < 3);
        pda  = BASE | (32'($urandom_range(0, 15)) << 2);
        pwd  = $urandom;
        psz  = 2'($urandom_range(0, 2));
        prun = 1'($urandom_range(0, 1));
      end
      drive_cycle(pf, pfa, pd, pwe, pda, pwd, psz, prun, gf, gd);
      if (gf) pf = 1'b0;
      if (gd) pd = 1'b0;
    end

    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, gf, gd);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and response router that shares one single-ported, pipelined memory between instruction fetch and the load/store path of the RV32I core. It grants at most one request per cycle, gives loads/stores priority with a bounded-starvation guarantee for fetch, and routes each read response back to its owner one cycle later. It also drives the PC-hold stall for the fetch stage. It sits between the PC/fetch logic, the execute-stage memory signals (ALU_out address, rs2 store data, access_size, RdUn, MemRW) and the memory instance.

## Interface
Parameters:
- STARVE_LIMIT, 4, max consecutive denied fetch cycles before fetch is forced ahead of data; legal range 1..15
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request (read, WORD)
- f_addr  in  ADDR_W  fetch address (PC_next)
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- f_stall  out  1  f_req & ~f_gnt; holds PC and instruction register
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  2  access size (BYTE/HALFWORD/WORD encoding)
- d_rdun  in  1  unsigned load
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- m_en  out  1  memory request strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_size  out  2  memory access size
- m_rdun  out  1  memory unsigned-read flag
- m_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Grant (combinational): if d_req and starve_cnt < STARVE_LIMIT -> d_gnt; else if f_req -> f_gnt; else if d_req -> d_gnt. Never both grants in one cycle.
- Memory drive: m_en = f_gnt | d_gnt. On f_gnt: m_addr=f_addr, m_we=0, m_size=WORD, m_rdun=0, m_wdata=0. On d_gnt: d_* passed straight through. No grant: m_en=0, m_we=0, other m_* = 0.
- starve_cnt (4 bits): increments when f_req & ~f_gnt, saturating at STARVE_LIMIT; clears when f_gnt or ~f_req.
- Response FSM (state = owner of the read returning this cycle): IDLE, RESP_F, RESP_D. Next state: RESP_F if f_gnt; RESP_D if d_gnt & ~d_we; otherwise IDLE. Transitions are legal from any state (back-to-back pipelined reads).
- Routing: in RESP_F, f_rvalid=1, f_rdata=m_rdata; in RESP_D, d_rvalid=1, d_rdata=m_rdata. Inactive rdata outputs are driven 0.
- Stores complete on d_gnt; they produce no d_rvalid.
- Requesters hold request fields stable until granted; the arbiter does not register requests.

## Timing
- Reset (reset_n low, any time): state=IDLE, starve_cnt=0; f_gnt, d_gnt, m_en, m_we, f_rvalid, d_rvalid = 0; all data/address outputs 0; f_stall = f_req. A read in flight when reset asserts is dropped and its response is not routed.
- Grant latency is 0 cycles (same-cycle); read response latency is exactly 1 cycle after the grant.
- Throughput is one access per cycle. A continuous d_req stream delays fetch by at most STARVE_LIMIT cycles; fetch then wins for exactly one cycle and starve_cnt clears.
- Simultaneous events: f_req and d_req with starve_cnt < LIMIT -> data wins and starve_cnt increments; at LIMIT -> fetch wins.
- A response cycle and a new grant may coincide; the routing uses the registered state, and the grant uses the current requests.

## Test plan
- Fetch only: f_req=1, f_addr=0x0100_0000 for 3 cycles -> f_gnt=1 every cycle, m_en=1, m_we=0, m_size=WORD; f_rvalid=1 each following cycle with f_rdata=m_rdata; f_stall=0.
- Load collision: f_req and d_req (load, 0x0100_0010, BYTE, d_rdun=1) in the same cycle -> d_gnt=1, f_gnt=0, f_stall=1, m_rdun=1; next cycle d_rvalid=1, f_rvalid=0, and fetch is granted.
- Store: d_req=1, d_we=1, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF; next cycle d_rvalid=0 and state=IDLE.
- Starvation with STARVE_LIMIT=4: d_req and f_req held high -> d_gnt for 4 cycles, f_gnt in cycle 5, then d_gnt resumes; starve_cnt reads 0,1,2,3,4,0.
- Reset mid-read: grant a fetch read, then pull reset_n low before the next edge -> f_rvalid stays 0, all outputs reach their reset values asynchronously, and after release the first f_req is granted normally.
